// File: rtl/bn_channel_scheduler.sv
// Frame scheduler feeding one sample at a time through an external batch_norm core.
// Holds per-channel BN parameters, sequences channels/pixels and returns results with backpressure.
module bn_channel_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int PIX_PER_CH = 8,
    parameter int TIMEOUT    = 64,
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW  = (PIX_PER_CH > 1) ? $clog2(PIX_PER_CH) : 1,
    localparam int WDW = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err,
    input  logic                  p_wr_en,
    input  logic [CW-1:0]         p_wr_ch,
    input  logic [1:0]            p_wr_sel,
    input  logic [DATA_WIDTH-1:0] p_wr_data,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bn_enable,
    output logic                  bn_read_flag,
    output logic [DATA_WIDTH-1:0] bn_input,
    output logic [DATA_WIDTH-1:0] bn_mean,
    output logic [DATA_WIDTH-1:0] bn_std,
    output logic [DATA_WIDTH-1:0] bn_gamma,
    output logic [DATA_WIDTH-1:0] bn_beta,
    input  logic                  bn_ready,
    input  logic                  bn_done,
    input  logic [DATA_WIDTH-1:0] bn_output,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         out_ch,
    output logic [PW-1:0]         out_pix,
    input  logic                  out_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_READY, S_FEED, S_WAIT_DONE, S_OUTPUT, S_DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] Q_ONE = DATA_WIDTH'(4096);

    state_t                  state_q, state_d;
    logic [CW-1:0]           chCnt_q, chCnt_d;
    logic [PW-1:0]           pixCnt_q, pixCnt_d;
    logic [WDW-1:0]          wdCnt_q, wdCnt_d;
    logic                    err_q, err_d;
    logic                    readFlag_q, readFlag_d;
    logic [DATA_WIDTH-1:0]   bnInput_q, bnInput_d;
    logic [DATA_WIDTH-1:0]   outData_q, outData_d;
    logic [DATA_WIDTH-1:0]   bnMean_q, bnMean_d, bnStd_q, bnStd_d;
    logic [DATA_WIDTH-1:0]   bnGamma_q, bnGamma_d, bnBeta_q, bnBeta_d;

    logic [DATA_WIDTH-1:0]   meanTab_q  [NUM_CH];
    logic [DATA_WIDTH-1:0]   stdTab_q   [NUM_CH];
    logic [DATA_WIDTH-1:0]   gammaTab_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   betaTab_q  [NUM_CH];

    logic wrOk;
    assign wrOk = p_wr_en && (state_q == S_IDLE) && ({1'b0, p_wr_ch} < (CW+1)'(NUM_CH));

    // Parameter table resets to the identity transform (mean 0, std 1.0, gamma 1.0, beta 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                meanTab_q[i]  <= '0;
                stdTab_q[i]   <= Q_ONE;
                gammaTab_q[i] <= Q_ONE;
                betaTab_q[i]  <= '0;
            end
        end else if (wrOk) begin
            case (p_wr_sel)
                2'd0: meanTab_q[p_wr_ch]  <= p_wr_data;
                2'd1: stdTab_q[p_wr_ch]   <= p_wr_data;
                2'd2: gammaTab_q[p_wr_ch] <= p_wr_data;
                2'd3: betaTab_q[p_wr_ch]  <= p_wr_data;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        chCnt_d    = chCnt_q;
        pixCnt_d   = pixCnt_q;
        wdCnt_d    = wdCnt_q;
        err_d      = err_q;
        readFlag_d = 1'b0;
        bnInput_d  = bnInput_q;
        outData_d  = outData_q;
        bnMean_d   = bnMean_q;
        bnStd_d    = bnStd_q;
        bnGamma_d  = bnGamma_q;
        bnBeta_d   = bnBeta_q;

        if (p_wr_en && state_q != S_IDLE)
            err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d    = 1'b0;
                    chCnt_d  = '0;
                    pixCnt_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                bnMean_d  = meanTab_q[chCnt_q];
                bnStd_d   = stdTab_q[chCnt_q];
                bnGamma_d = gammaTab_q[chCnt_q];
                bnBeta_d  = betaTab_q[chCnt_q];
                wdCnt_d   = '0;
                state_d   = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (bn_ready)
                    state_d = S_FEED;
                else if (wdCnt_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else
                    wdCnt_d = wdCnt_q + 1'b1;
            end
            S_FEED: begin
                if (in_valid) begin
                    bnInput_d  = in_data;
                    readFlag_d = 1'b1;
                    wdCnt_d    = '0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bn_done) begin
                    outData_d = bn_output;
                    state_d   = S_OUTPUT;
                end else if (wdCnt_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else
                    wdCnt_d = wdCnt_q + 1'b1;
            end
            S_OUTPUT: begin
                // Counters only wrap here, so indices never leave range.
                if (out_ready) begin
                    if (pixCnt_q < PW'(PIX_PER_CH - 1)) begin
                        pixCnt_d = pixCnt_q + 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        pixCnt_d = '0;
                        if (chCnt_q < CW'(NUM_CH - 1)) begin
                            chCnt_d = chCnt_q + 1'b1;
                            state_d = S_LOAD;
                        end else
                            state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chCnt_q    <= '0;
            pixCnt_q   <= '0;
            wdCnt_q    <= '0;
            err_q      <= 1'b0;
            readFlag_q <= 1'b0;
            bnInput_q  <= '0;
            outData_q  <= '0;
            bnMean_q   <= '0;
            bnStd_q    <= '0;
            bnGamma_q  <= '0;
            bnBeta_q   <= '0;
        end else begin
            state_q    <= state_d;
            chCnt_q    <= chCnt_d;
            pixCnt_q   <= pixCnt_d;
            wdCnt_q    <= wdCnt_d;
            err_q      <= err_d;
            readFlag_q <= readFlag_d;
            bnInput_q  <= bnInput_d;
            outData_q  <= outData_d;
            bnMean_q   <= bnMean_d;
            bnStd_q    <= bnStd_d;
            bnGamma_q  <= bnGamma_d;
            bnBeta_q   <= bnBeta_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign in_ready     = (state_q == S_FEED);
    assign bn_enable    = (state_q == S_LOAD);
    assign out_valid    = (state_q == S_OUTPUT);
    assign err          = err_q;
    assign bn_read_flag = readFlag_q;
    assign bn_input     = bnInput_q;
    assign bn_mean      = bnMean_q;
    assign bn_std       = bnStd_q;
    assign bn_gamma     = bnGamma_q;
    assign bn_beta      = bnBeta_q;
    assign out_data     = outData_q;
    assign out_ch       = chCnt_q;
    assign out_pix      = pixCnt_q;

endmodule

// File: doc/bn_channel_scheduler.md
BN_CHANNEL_SCHEDULER -- requirements
Module: bn_channel_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 16, signed Q4.12 sample/parameter width.
- NUM_CH, 4, channels per frame.
- PIX_PER_CH, 8, samples per channel.
- TIMEOUT, 64, max cycles in WAIT_READY or WAIT_DONE.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, frame start pulse.
- busy, out, 1, high in any state other than IDLE.
- frame_done, out, 1, one-cycle pulse at frame completion.
- err, out, 1, sticky error flag.
- p_wr_en, in, 1, parameter write strobe.
- p_wr_ch, in, clog2(NUM_CH), channel to write.
- p_wr_sel, in, 2, field select: 0 mean, 1 std, 2 gamma, 3 beta.
- p_wr_data, in, DATA_WIDTH, parameter value.
- in_valid, in, 1, input sample valid.
- in_data, in, DATA_WIDTH, input sample.
- in_ready, out, 1, input sample accept.
- bn_enable, out, 1, batch_norm enable.
- bn_read_flag, out, 1, batch_norm bnfifo_read_flag.
- bn_input, out, DATA_WIDTH, sample to batch_norm.
- bn_mean, out, DATA_WIDTH, mean_mov to batch_norm.
- bn_std, out, DATA_WIDTH, std_mov to batch_norm.
- bn_gamma, out, DATA_WIDTH, gamma to batch_norm.
- bn_beta, out, DATA_WIDTH, beta to batch_norm.
- bn_ready, in, 1, batch_norm ready.
- bn_done, in, 1, batch_norm bn_done.
- bn_output, in, DATA_WIDTH, batch_norm result.
- out_valid, out, 1, result valid.
- out_data, out, DATA_WIDTH, result value.
- out_ch, out, clog2(NUM_CH), channel of result.
- out_pix, out, clog2(PIX_PER_CH), pixel index of result.
- out_ready, in, 1, result accept.

Function
REQ-003 Register file SHALL hold 4 fields x NUM_CH entries; a write SHALL take effect on the clock edge of p_wr_en, only in IDLE.
REQ-004 p_wr_en outside IDLE SHALL be ignored and SHALL set err.
REQ-005 FSM states SHALL be IDLE, LOAD, WAIT_READY, FEED, WAIT_DONE, OUTPUT, DONE.
REQ-006 IDLE: start=1 SHALL clear err, ch_cnt, pix_cnt and go to LOAD; start outside IDLE SHALL be ignored.
REQ-007 LOAD: bn_mean/std/gamma/beta SHALL register entry ch_cnt; bn_enable SHALL be high exactly this one cycle; next state WAIT_READY.
REQ-008 bn_mean/std/gamma/beta SHALL stay stable from the cycle after LOAD until the next LOAD.
REQ-009 WAIT_READY: bn_ready=1 SHALL go to FEED.
REQ-010 FEED: in_ready SHALL be high (combinational of state only); on in_valid, in_data SHALL latch into bn_input, bn_read_flag SHALL be high the following cycle only, next state WAIT_DONE.
REQ-011 bn_input SHALL hold its value until the next FEED handshake.
REQ-012 WAIT_DONE: bn_done=1 SHALL latch bn_output into out_data and go to OUTPUT.
REQ-013 OUTPUT: out_valid SHALL be high with out_ch=ch_cnt and out_pix=pix_cnt; data SHALL hold while out_ready=0; on out_ready=1 advance per REQ-014.
REQ-014 Advance: pix_cnt<PIX_PER_CH-1 -> pix_cnt++, go to LOAD; else pix_cnt=0 and, if ch_cnt<NUM_CH-1, ch_cnt++ and go to LOAD, else go to DONE.
REQ-015 DONE: frame_done SHALL be high one cycle; next state IDLE.
REQ-016 Latency from in handshake to out_valid SHALL be batch_norm latency plus 2 cycles; no sample SHALL be accepted while a previous result is unconsumed.
REQ-017 Watchdog SHALL count cycles in WAIT_READY/WAIT_DONE, reset on state entry; reaching TIMEOUT SHALL set err and go to IDLE without frame_done.
REQ-018 in_valid held in any state other than FEED SHALL not be consumed.
REQ-019 Counters SHALL wrap only via REQ-014; no out-of-range index SHALL be generated.

Reset
REQ-020 rst=1 SHALL, at the next edge, force IDLE from any state, including mid-frame.
REQ-021 On that reset, every output SHALL be 0 (busy, frame_done, err, in_ready, bn_enable, bn_read_flag, bn_input, bn_mean, bn_std, bn_gamma, bn_beta, out_valid, out_data, out_ch, out_pix) and the counters SHALL be 0.
REQ-022 Register file contents SHALL be reset to mean=0, std=4096, gamma=4096, beta=0.

Verification
REQ-023 Single-sample run, NUM_CH=1, PIX_PER_CH=1, with batch_norm instance; ch0 = {4096, 2048, 4096, 0}, in_data=8192 -> out_data=8192 (2.0), then frame_done pulse.
REQ-024 Full frame, 4 ch x 8 pix with distinct params; ch1 = {4096, 4096, 8192, 2048}, input 6144 -> 6144. Check out_ch/out_pix sequence (0,0)..(3,7), exactly 32 results, one frame_done.
REQ-025 Backpressure: out_ready low 5 cycles -> out_valid and out_data held, in_ready low, no bn_enable.
REQ-026 Bubble input: in_valid gaps of 3 cycles -> no extra bn_read_flag; one bn_read_flag per sample.
REQ-027 Errors: p_wr_en while busy -> err=1 and the entry unchanged. Stub bn_done never asserted -> err=1 after 64 cycles, then IDLE.
REQ-028 Reset asserted during WAIT_DONE of pixel 3 -> all outputs 0 next cycle; a new start gives a clean full frame from (0,0).
